sparse_index_intersect: RTL and testbench

- Streaming, parametrised successor to the fixed 32-bit registered less/greater/equal comparator.
- Consumes two ascending-sorted (index, value) streams: row nonzeros of a sparse operand, and a column segment of the other operand.
- Emits only the pairs whose indices are equal, with valid/ready handshakes and a completion pulse.
- Feeds the MAC stage of the sparse-dense multiply datapath.

---
 rtl/sparse_index_intersect_pkg.sv | 22 ++
 rtl/sparse_index_intersect_cmp.sv | 23 ++
 rtl/sparse_index_intersect.sv | 156 +++++++++++++++
 tb/tb_sparse_index_intersect.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_index_intersect_pkg.sv
// Shared types for the sparse merge units: compare result, intersect FSM states and default widths.
package sparse_pkg;

  localparam int IDX_W_DEF = 32;
  localparam int VAL_W_DEF = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    CMP_LT,
    CMP_EQ,
    CMP_GT
  } cmp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN_A,
    ST_DRAIN_B,
    ST_FLUSH
  } isect_state_e;

endpackage

// File: rtl/sparse_index_intersect_cmp.sv
// Combinational three-way index comparator, signed or unsigned by parameter.
module idx_cmp
  import sparse_pkg::*;
#(
  parameter int IDX_W      = IDX_W_DEF,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic [IDX_W-1:0] a_i,
  input  logic [IDX_W-1:0] b_i,
  output cmp_e             cmp_o
);

  logic lt;

  always_comb begin
    if (SIGNED_CMP) lt = $signed(a_i) < $signed(b_i);
    else            lt = a_i < b_i;
    if (a_i == b_i) cmp_o = CMP_EQ;
    else if (lt)    cmp_o = CMP_LT;
    else            cmp_o = CMP_GT;
  end

endmodule

// File: rtl/sparse_index_intersect.sv
// Merges two ascending (index, value) streams and emits only pairs with equal indices.
module sparse_index_intersect
  import sparse_pkg::*;
#(
  parameter int IDX_W      = IDX_W_DEF,
  parameter int VAL_W      = VAL_W_DEF,
  parameter bit SIGNED_CMP = 1'b0,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [VAL_W-1:0] a_val,
  input  logic             a_last,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [IDX_W-1:0] b_idx,
  input  logic [VAL_W-1:0] b_val,
  input  logic             b_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [IDX_W-1:0] m_idx,
  output logic [VAL_W-1:0] m_a_val,
  output logic [VAL_W-1:0] m_b_val,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  isect_state_e     state_q;
  logic             a_hv_q, a_last_q, b_hv_q, b_last_q;
  logic [IDX_W-1:0] a_idx_q, b_idx_q, m_idx_q;
  logic [VAL_W-1:0] a_val_q, b_val_q, m_a_val_q, m_b_val_q;
  logic             m_valid_q, done_q;
  logic [CNT_W-1:0] match_cnt_q;

  cmp_e cmp;
  logic out_free, pop_a, pop_b, match, a_take, b_take, a_ex, b_ex;

  idx_cmp #(.IDX_W(IDX_W), .SIGNED_CMP(SIGNED_CMP)) u_cmp (
    .a_i  (a_idx_q),
    .b_i  (b_idx_q),
    .cmp_o(cmp)
  );

  // Pops depend only on registered heads and m_ready, never on the input valids.
  always_comb begin
    out_free = !m_valid_q || m_ready;
    pop_a    = 1'b0;
    pop_b    = 1'b0;
    match    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (a_hv_q && b_hv_q) begin
          match = (cmp == CMP_EQ) && out_free;
          pop_a = (cmp == CMP_LT) || match;
          pop_b = (cmp == CMP_GT) || match;
        end
      end
      ST_DRAIN_A: pop_a = a_hv_q;
      ST_DRAIN_B: pop_b = b_hv_q;
      default: ;
    endcase
  end

  // A head that held the last beat is never refilled in the cycle it is popped.
  assign a_ready = (state_q == ST_RUN || state_q == ST_DRAIN_A) && (!a_hv_q || (pop_a && !a_last_q));
  assign b_ready = (state_q == ST_RUN || state_q == ST_DRAIN_B) && (!b_hv_q || (pop_b && !b_last_q));
  assign a_take  = a_valid && a_ready;
  assign b_take  = b_valid && b_ready;
  assign a_ex    = pop_a && a_last_q;
  assign b_ex    = pop_b && b_last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_hv_q      <= 1'b0;
      a_last_q    <= 1'b0;
      a_idx_q     <= '0;
      a_val_q     <= '0;
      b_hv_q      <= 1'b0;
      b_last_q    <= 1'b0;
      b_idx_q     <= '0;
      b_val_q     <= '0;
      m_valid_q   <= 1'b0;
      m_idx_q     <= '0;
      m_a_val_q   <= '0;
      m_b_val_q   <= '0;
      done_q      <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (a_take) begin
        a_hv_q   <= 1'b1;
        a_idx_q  <= a_idx;
        a_val_q  <= a_val;
        a_last_q <= a_last;
      end else if (pop_a) begin
        a_hv_q <= 1'b0;
      end
      if (b_take) begin
        b_hv_q   <= 1'b1;
        b_idx_q  <= b_idx;
        b_val_q  <= b_val;
        b_last_q <= b_last;
      end else if (pop_b) begin
        b_hv_q <= 1'b0;
      end
      if (match) begin
        m_valid_q <= 1'b1;
        m_idx_q   <= a_idx_q;
        m_a_val_q <= a_val_q;
        m_b_val_q <= b_val_q;
        if (match_cnt_q != '1) match_cnt_q <= match_cnt_q + 1'b1;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_RUN;
            match_cnt_q <= '0;
            a_hv_q      <= 1'b0;
            b_hv_q      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (a_ex && b_ex) state_q <= ST_FLUSH;
          else if (a_ex)    state_q <= ST_DRAIN_B;
          else if (b_ex)    state_q <= ST_DRAIN_A;
        end
        ST_DRAIN_A: if (a_ex) state_q <= ST_FLUSH;
        ST_DRAIN_B: if (b_ex) state_q <= ST_FLUSH;
        ST_FLUSH: begin
          if (out_free) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_valid   = m_valid_q;
  assign m_idx     = m_idx_q;
  assign m_a_val   = m_a_val_q;
  assign m_b_val   = m_b_val_q;
  assign busy      = state_q != ST_IDLE;
  assign done      = done_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_sparse_index_intersect.sv
// Drives unsigned and signed intersect instances from directed tables and random sorted streams.
module tb_sparse_index_intersect;

  localparam int IW = 32;
  localparam int VW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n, sel, start, a_valid, b_valid, a_last, b_last, m_ready;
  logic [IW-1:0] a_idx, b_idx;
  logic [VW-1:0] a_val, b_val;

  logic          u_a_ready, u_b_ready, u_m_valid, u_busy, u_done;
  logic          s_a_ready, s_b_ready, s_m_valid, s_busy, s_done;
  logic [IW-1:0] u_m_idx, s_m_idx;
  logic [VW-1:0] u_m_a_val, u_m_b_val, s_m_a_val, s_m_b_val;
  logic [CW-1:0] u_match_cnt, s_match_cnt;

  logic          a_ready, b_ready, m_valid, busy, done;
  logic [IW-1:0] m_idx;
  logic [VW-1:0] m_a_val, m_b_val;
  logic [CW-1:0] match_cnt;
  logic          u_start, s_start;

  assign u_start   = start && !sel;
  assign s_start   = start && sel;
  assign a_ready   = sel ? s_a_ready : u_a_ready;
  assign b_ready   = sel ? s_b_ready : u_b_ready;
  assign m_valid   = sel ? s_m_valid : u_m_valid;
  assign busy      = sel ? s_busy : u_busy;
  assign done      = sel ? s_done : u_done;
  assign m_idx     = sel ? s_m_idx : u_m_idx;
  assign m_a_val   = sel ? s_m_a_val : u_m_a_val;
  assign m_b_val   = sel ? s_m_b_val : u_m_b_val;
  assign match_cnt = sel ? s_match_cnt : u_match_cnt;

  sparse_index_intersect #(.IDX_W(IW), .VAL_W(VW), .SIGNED_CMP(1'b0), .CNT_W(CW)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(u_start),
    .a_valid(a_valid), .a_ready(u_a_ready), .a_idx(a_idx), .a_val(a_val), .a_last(a_last),
    .b_valid(b_valid), .b_ready(u_b_ready), .b_idx(b_idx), .b_val(b_val), .b_last(b_last),
    .m_valid(u_m_valid), .m_ready(m_ready), .m_idx(u_m_idx), .m_a_val(u_m_a_val),
    .m_b_val(u_m_b_val), .busy(u_busy), .done(u_done), .match_cnt(u_match_cnt)
  );

  sparse_index_intersect #(.IDX_W(IW), .VAL_W(VW), .SIGNED_CMP(1'b1), .CNT_W(CW)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .a_valid(a_valid), .a_ready(s_a_ready), .a_idx(a_idx), .a_val(a_val), .a_last(a_last),
    .b_valid(b_valid), .b_ready(s_b_ready), .b_idx(b_idx), .b_val(b_val), .b_last(b_last),
    .m_valid(s_m_valid), .m_ready(m_ready), .m_idx(s_m_idx), .m_a_val(s_m_a_val),
    .m_b_val(s_m_b_val), .busy(s_busy), .done(s_done), .match_cnt(s_match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             sgn;
    logic [7:0]       stLo;
    logic [7:0]       stHi;
    logic [7:0]       rdyChk;
    logic [2:0]       aLen;
    logic [2:0]       bLen;
    logic [2:0]       expN;
    logic [0:3][31:0] aIdx;
    logic [0:3][31:0] bIdx;
    logic [0:3][31:0] expIdx;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] aI[16], aV[16], bI[16], bV[16];
  int          aLen, bLen;
  logic [31:0] expI[$], expA[$], expB[$];
  int          nChk = 0;
  int          nPass = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mkVec(input bit sgn, input int stLo, input int stHi, input int rdyChk,
                                 input int aN, input logic [0:3][31:0] aIdx,
                                 input int bN, input logic [0:3][31:0] bIdx,
                                 input int eN, input logic [0:3][31:0] eIdx);
    vec_t v;
    v.sgn = sgn; v.stLo = 8'(stLo); v.stHi = 8'(stHi); v.rdyChk = 8'(rdyChk);
    v.aLen = 3'(aN); v.bLen = 3'(bN); v.expN = 3'(eN);
    v.aIdx = aIdx; v.bIdx = bIdx; v.expIdx = eIdx;
    return v;
  endfunction

  // Table values are a fixed function of the index so expected value pairs follow from the index.
  task automatic loadVec(input vec_t v);
    sel  = v.sgn;
    aLen = int'(v.aLen);
    bLen = int'(v.bLen);
    for (int i = 0; i < 4; i++) begin
      aI[i] = v.aIdx[i]; aV[i] = v.aIdx[i] ^ 32'hA5A5_0000;
      bI[i] = v.bIdx[i]; bV[i] = v.bIdx[i] ^ 32'h0000_C3C3;
    end
    expI.delete(); expA.delete(); expB.delete();
    for (int i = 0; i < int'(v.expN); i++) begin
      expI.push_back(v.expIdx[i]);
      expA.push_back(v.expIdx[i] ^ 32'hA5A5_0000);
      expB.push_back(v.expIdx[i] ^ 32'h0000_C3C3);
    end
  endtask

  task automatic applyStimulus(input string tag, input bit rnd, input int stLo, input int stHi,
                               input int rdyChkCyc, input bit abortOnM);
    int ai, bi, cyc;
    bit finished, aborted, prevStall;
    logic [31:0] pI, pA, pB;
    logic [31:0] gI[$], gA[$], gB[$];
    ai = 0; bi = 0; cyc = 0; finished = 0; aborted = 0; prevStall = 0;
    pI = '0; pA = '0; pB = '0;
    @(negedge clk);
    start = 1'b1; a_valid = 1'b0; b_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, " busy after start"}, 64'(busy), 64'd1);
    while (!finished && !aborted && cyc < 300) begin
      a_valid = (ai < aLen) && (!rnd || $urandom_range(3) != 0);
      a_idx   = (ai < aLen) ? aI[ai] : '0;
      a_val   = (ai < aLen) ? aV[ai] : '0;
      a_last  = (ai == aLen - 1);
      b_valid = (bi < bLen) && (!rnd || $urandom_range(3) != 0);
      b_idx   = (bi < bLen) ? bI[bi] : '0;
      b_val   = (bi < bLen) ? bV[bi] : '0;
      b_last  = (bi == bLen - 1);
      m_ready = rnd ? ($urandom_range(3) != 0) : !(cyc >= stLo && cyc <= stHi);
      #1;
      if (prevStall) begin
        checkOutput({tag, " stall m_valid held"}, 64'(m_valid), 64'd1);
        checkOutput({tag, " stall m_idx held"}, 64'(m_idx), 64'(pI));
        checkOutput({tag, " stall m_a_val held"}, 64'(m_a_val), 64'(pA));
        checkOutput({tag, " stall m_b_val held"}, 64'(m_b_val), 64'(pB));
      end
      if (cyc == rdyChkCyc) begin
        checkOutput({tag, " a_ready low in EQ stall"}, 64'(a_ready), 64'd0);
        checkOutput({tag, " b_ready low in EQ stall"}, 64'(b_ready), 64'd0);
      end
      prevStall = m_valid && !m_ready;
      pI = m_idx; pA = m_a_val; pB = m_b_val;
      if (a_valid && a_ready) ai++;
      if (b_valid && b_ready) bi++;
      if (m_valid && m_ready) begin
        gI.push_back(m_idx); gA.push_back(m_a_val); gB.push_back(m_b_val);
      end
      if (done) begin
        finished = 1;
        checkOutput({tag, " busy low with done"}, 64'(busy), 64'd0);
      end
      if (abortOnM && m_valid) aborted = 1;
      if (!aborted) begin
        @(negedge clk);
        cyc++;
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    if (!abortOnM) begin
      checkOutput({tag, " done seen"}, 64'(finished), 64'd1);
      checkOutput({tag, " done one cycle"}, 64'(done), 64'd0);
      checkOutput({tag, " match_cnt"}, 64'(match_cnt), 64'(expI.size()));
      checkOutput({tag, " A beats accepted"}, 64'(ai), 64'(aLen));
      checkOutput({tag, " B beats accepted"}, 64'(bi), 64'(bLen));
      checkOutput({tag, " match beats"}, 64'(gI.size()), 64'(expI.size()));
      for (int k = 0; k < expI.size(); k++) begin
        if (k < gI.size()) begin
          checkOutput($sformatf("%s beat%0d idx", tag, k), 64'(gI[k]), 64'(expI[k]));
          checkOutput($sformatf("%s beat%0d a_val", tag, k), 64'(gA[k]), 64'(expA[k]));
          checkOutput($sformatf("%s beat%0d b_val", tag, k), 64'(gB[k]), 64'(expB[k]));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cur;
    rst_n = 1'b0; sel = 1'b0; start = 1'b0; m_ready = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
    a_idx = '0; b_idx = '0; a_val = '0; b_val = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset a_ready", 64'(a_ready), 64'd0);
    checkOutput("reset m_valid", 64'(m_valid), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset match_cnt", 64'(match_cnt), 64'd0);
    rst_n = 1'b1;

    vecs[0] = mkVec(0, 255, 0, 255, 4, {32'd1, 32'd3, 32'd5, 32'd7}, 3, {32'd3, 32'd4, 32'd7, 32'd0},
                    2, {32'd3, 32'd7, 32'd0, 32'd0});
    vecs[1] = mkVec(0, 255, 0, 255, 2, {32'd0, 32'd2, 32'd0, 32'd0}, 2, {32'd1, 32'd3, 32'd0, 32'd0},
                    0, {32'd0, 32'd0, 32'd0, 32'd0});
    vecs[2] = mkVec(0, 255, 0, 255, 1, {32'd5, 32'd0, 32'd0, 32'd0}, 4, {32'd1, 32'd5, 32'd9, 32'd12},
                    1, {32'd5, 32'd0, 32'd0, 32'd0});
    vecs[3] = mkVec(0, 3, 7, 5, 3, {32'd1, 32'd2, 32'd3, 32'd0}, 3, {32'd1, 32'd2, 32'd3, 32'd0},
                    3, {32'd1, 32'd2, 32'd3, 32'd0});
    vecs[4] = mkVec(1, 255, 0, 255, 2, {32'hFFFF_FFFC, 32'd2, 32'd0, 32'd0},
                    2, {32'hFFFF_FFFC, 32'd3, 32'd0, 32'd0}, 1, {32'hFFFF_FFFC, 32'd0, 32'd0, 32'd0});
    vecs[5] = mkVec(1, 255, 0, 255, 2, {32'hFFFF_FFFC, 32'd2, 32'd0, 32'd0},
                    2, {32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0}, 1, {32'd2, 32'd0, 32'd0, 32'd0});
    vecs[6] = mkVec(0, 255, 0, 255, 2, {32'd1, 32'h8000_0000, 32'd0, 32'd0},
                    1, {32'h8000_0000, 32'd0, 32'd0, 32'd0}, 1, {32'h8000_0000, 32'd0, 32'd0, 32'd0});

    for (int v = 0; v < 7; v++) begin
      loadVec(vecs[v]);
      applyStimulus($sformatf("vec%0d", v), 1'b0, int'(vecs[v].stLo), int'(vecs[v].stHi),
                    (vecs[v].rdyChk == 8'd255) ? -1 : int'(vecs[v].rdyChk), 1'b0);
    end

    // Reset in the middle of a job with a match held in the output register.
    loadVec(vecs[0]);
    applyStimulus("midreset", 1'b0, 0, 1000, -1, 1'b1);
    checkOutput("midreset m_valid before reset", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset a_ready", 64'(a_ready), 64'd0);
    checkOutput("midreset b_ready", 64'(b_ready), 64'd0);
    checkOutput("midreset m_valid", 64'(m_valid), 64'd0);
    checkOutput("midreset m_idx", 64'(m_idx), 64'd0);
    checkOutput("midreset m_a_val", 64'(m_a_val), 64'd0);
    checkOutput("midreset m_b_val", 64'(m_b_val), 64'd0);
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset done", 64'(done), 64'd0);
    checkOutput("midreset match_cnt", 64'(match_cnt), 64'd0);
    rst_n = 1'b1;
    m_ready = 1'b1;
    applyStimulus("after reset", 1'b0, 255, 0, -1, 1'b0);

    // Random sorted streams; the expected set is the plain index intersection.
    for (int j = 0; j < 40; j++) begin
      sel  = j[0];
      cur  = (sel ? -12 : 0) + int'($urandom_range(0, 3));
      aLen = int'($urandom_range(1, 8));
      for (int i = 0; i < aLen; i++) begin
        aI[i] = 32'(cur); aV[i] = $urandom; cur += int'($urandom_range(1, 3));
      end
      cur  = (sel ? -12 : 0) + int'($urandom_range(0, 3));
      bLen = int'($urandom_range(1, 8));
      for (int i = 0; i < bLen; i++) begin
        bI[i] = 32'(cur); bV[i] = $urandom; cur += int'($urandom_range(1, 3));
      end
      expI.delete(); expA.delete(); expB.delete();
      for (int i = 0; i < aLen; i++)
        for (int k = 0; k < bLen; k++)
          if (aI[i] == bI[k]) begin
            expI.push_back(aI[i]); expA.push_back(aV[i]); expB.push_back(bV[k]);
          end
      applyStimulus($sformatf("rnd%0d", j), 1'b1, 0, 0, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
